acl_fifo_sched: RTL

- Packet-level read scheduler for the ACL ingress packet FIFO.
- Counts complete packets written into the FIFO and requests a permit/deny verdict from the ACL lookup for each head-of-queue packet.
- On permit, forwards the packet to the downstream AXI-stream port. On deny, drains it while holding the FIFO invalid control so the output is all zeros.
- Sits between the rx write side, the FIFO read controls (i_rd_valid, i_fifo_invalid) and the tx port.

---
 rtl/acl_fifo_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/acl_fifo_sched.sv
// acl_fifo_sched: packet-level read scheduler for the ACL ingress FIFO.
// Counts complete packets held in the FIFO, asks the ACL lookup for a
// permit/deny verdict on the head packet, then forwards it downstream or
// drains it with the FIFO invalid control held so the output reads zero.
//
// Optional feature macro: ACL_VERDICT_TIMEOUT_EN
//   defined   - WAIT_VERDICT gives up after TIMEOUT cycles, drops the packet
//               and pulses o_timeout for one cycle.
//   undefined - WAIT_VERDICT waits indefinitely; o_timeout is tied low.
//
// Handshake rules: a verdict transfers when o_verdict_ready & i_verdict_valid;
// a downstream beat transfers when o_txd_tvalid & i_txd_tready; a FIFO word is
// popped whenever o_rd_valid is high. o_state exposes the FSM encoding
// (0 IDLE, 1 WAIT_VERDICT, 2 FORWARD, 3 DROP) for observation.
module acl_fifo_sched #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int DROP_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rxd_tvalid,
  input  logic              i_rx_tlast,
  input  logic              i_fifo_full,
  input  logic              i_fifo_empty,
  input  logic              i_head_tlast,
  input  logic              i_verdict_valid,
  input  logic              i_verdict_permit,
  output logic              o_verdict_ready,
  input  logic              i_txd_tready,
  output logic              o_txd_tvalid,
  output logic              o_rd_valid,
  output logic              o_fifo_invalid,
  output logic [CNT_W-1:0]  o_pkt_cnt,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic              o_pkt_ovf,
  output logic              o_timeout,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_VERDICT = 2'd1,
    FORWARD      = 2'd2,
    DROP         = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  state_t state, state_next;
  logic   verdict_ready;
  logic   txd_tvalid;
  logic   rd_valid;
  logic   wr_done;
  logic   rd_done;

`ifdef ACL_VERDICT_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] wait_cnt;
  logic          expire;
  logic          timeout_q;
`endif

  assign wr_done = i_rxd_tvalid & i_rx_tlast & ~i_fifo_full;
  assign rd_done = rd_valid & i_head_tlast;

  assign o_verdict_ready = verdict_ready;
  assign o_txd_tvalid    = txd_tvalid;
  assign o_rd_valid      = rd_valid;
  assign o_fifo_invalid  = (state == DROP);
  assign o_state         = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the combinational strobes.
  always_comb begin
    state_next    = state;
    verdict_ready = 1'b0;
    txd_tvalid    = 1'b0;
    rd_valid      = 1'b0;
`ifdef ACL_VERDICT_TIMEOUT_EN
    expire        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (o_pkt_cnt != '0) state_next = WAIT_VERDICT;
      end
      WAIT_VERDICT: begin
        verdict_ready = 1'b1;
        // A verdict arriving in the expiry cycle takes priority.
        if (i_verdict_valid) begin
          state_next = i_verdict_permit ? FORWARD : DROP;
        end
`ifdef ACL_VERDICT_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          state_next = DROP;
          expire     = 1'b1;
        end
`endif
      end
      FORWARD: begin
        txd_tvalid = ~i_fifo_empty;
        rd_valid   = ~i_fifo_empty & i_txd_tready;
        if (rd_valid & i_head_tlast) state_next = IDLE;
      end
      DROP: begin
        rd_valid = ~i_fifo_empty;
        if (rd_valid & i_head_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Complete-packet counter with sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pkt_cnt <= '0;
      o_pkt_ovf <= 1'b0;
    end else if (wr_done && !rd_done) begin
      if (o_pkt_cnt == CNT_MAX) o_pkt_ovf <= 1'b1;
      else                      o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
    end else if (rd_done && !wr_done) begin
      o_pkt_cnt <= o_pkt_cnt - CNT_W'(1);
    end
  end

  // Saturating count of packets drained in DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_drop_cnt <= '0;
    end else if (state == DROP && rd_done && o_drop_cnt != DROP_MAX) begin
      o_drop_cnt <= o_drop_cnt + DROP_W'(1);
    end
  end

`ifdef ACL_VERDICT_TIMEOUT_EN
  // Cycles spent in WAIT_VERDICT; cleared whenever the state is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               wait_cnt <= '0;
    else if (state == WAIT_VERDICT && state_next == WAIT_VERDICT) wait_cnt <= wait_cnt + TW'(1);
    else                                                   wait_cnt <= '0;
  end

  // One-cycle timeout pulse, coincident with the first DROP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= expire;
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule
